axi_w_beat_gen: RTL and testbench
=================================

Name: axi_w_beat_gen

Overview:
- Read-side consumer of the write-data sync FIFO in the AXI4 interconnect.
- Takes one burst descriptor per AW transaction and pops exactly LEN+1 beats from the FIFO head.
- Presents the beats on an AXI4 W-style valid/ready channel, with WLAST asserted on the final beat.
- Serialises bursts in descriptor order. No data storage of its own beyond the control state.

Parameters:
- DATA_WIDTH, 32, width of FIFO entry and W data.
- LEN_WIDTH, 8, width of burst length field (AXI4 AxLEN; beats = len+1).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- desc_len_i  input  LEN_WIDTH  burst length minus one.
- desc_valid_i  input  1  descriptor valid.
- desc_ready_o  output  1  descriptor accepted when valid & ready.
- fifo_data_i  input  DATA_WIDTH  FIFO head data (combinational from FIFO).
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_rd_o  output  1  FIFO pop strobe.
- w_data_o  output  DATA_WIDTH  write beat data.
- w_last_o  output  1  last beat of burst.
- w_valid_o  output  1  beat valid.
- w_ready_i  input  1  downstream ready.
- busy_o  output  1  burst in progress.
- beats_left_o  output  LEN_WIDTH+1  beats remaining in the current burst, including the current beat.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- All flops clear asynchronously on rst, with these values:
  - State = IDLE, beat counter = 0.
  - desc_ready_o = 1, w_valid_o = 0, w_last_o = 0, fifo_rd_o = 0, busy_o = 0, beats_left_o = 0.
- States: IDLE, BURST.
- IDLE:
  - desc_ready_o = 1.
  - On a descriptor handshake, load cnt = desc_len_i + 1 (computed at LEN_WIDTH+1 bits, so len 255 gives 256) and go to BURST.
  - w_valid_o = 0 in IDLE.
- BURST:
  - w_valid_o = ~fifo_empty_i.
  - w_data_o = fifo_data_i, passed combinationally with zero added latency.
  - w_last_o = w_valid_o & (cnt == 1).
  - busy_o = 1.
  - beats_left_o = cnt.
- Beat handshake: beat = w_valid_o & w_ready_i.
  - fifo_rd_o = beat. This is a single combinational path w_ready_i -> fifo_rd_o.
  - The pop is never asserted while fifo_empty_i = 1.
- On each beat, cnt decrements.
- On the beat with cnt == 1, the burst ends: go to IDLE, or reload per the Optional Feature.
- FIFO empty mid-burst:
  - w_valid_o drops and cnt holds.
  - The burst resumes when data arrives; there is no timeout.
- Once w_valid_o is asserted, w_data_o and w_last_o must stay stable until the beat handshake completes. The FIFO head cannot change without a pop, so this holds by construction.
- Descriptors are never dropped. desc_ready_o = 0 throughout BURST, except as described in the Optional Feature.
- In IDLE, w_ready_i is ignored and fifo_rd_o = 0.
- Reset mid-burst:
  - Immediate return to IDLE; the remaining beat count is discarded.
  - The FIFO is reset separately by its owner.

Optional Feature:
- Macro: AXI_W_BEAT_GEN_BTB_EN.
- Defined (back-to-back bursts):
  - In BURST, desc_ready_o = (cnt == 1) & beat.
  - A descriptor accepted on the last beat reloads cnt = len + 1 and the block stays in BURST.
  - Result: zero idle cycles between bursts.
- Undefined:
  - desc_ready_o = 1 only in IDLE.
  - At least one bubble cycle (w_valid_o = 0) between consecutive bursts.

Test Plan:
- Single beat: reset, preload FIFO with 0xA5. Send desc len=0 -> next cycle w_valid_o=1, w_data_o=0xA5, w_last_o=1. With w_ready_i=1: one fifo_rd_o pulse, then IDLE, busy_o=0.
- Four-beat burst, continuous ready: FIFO holds 0x10..0x13, desc len=3 -> four consecutive beats with data 0x10,0x11,0x12,0x13. w_last_o only on 0x13. beats_left_o shows 4,3,2,1.
- Backpressure: desc len=1, w_ready_i low for 3 cycles -> w_valid_o held, data stable at the first entry, fifo_rd_o=0. Beats complete after ready rises.
- FIFO underrun: desc len=3 with the FIFO holding 2 entries -> 2 beats, then w_valid_o=0 with beats_left_o=2. Push 2 more entries -> remaining beats sent, last flagged on the 4th.
- Max length: desc len=255 with the FIFO kept fed -> exactly 256 beats, w_last_o on the 256th only, no counter wrap.
- Reset/back-to-back: assert rst after 2 beats of len=7 -> outputs return to reset values immediately. Then two descriptors len=1, len=2:
  - With AXI_W_BEAT_GEN_BTB_EN: 5 beats with no gap.
  - Without it: a 1-cycle bubble after beat 2.

Source files
------------

// File: rtl/axi_w_beat_gen.sv
// axi_w_beat_gen: read-side consumer of the write-data sync FIFO.
// Takes one burst descriptor (len = beats - 1) at a time and pops exactly
// len+1 beats from the FIFO head onto a W-style valid/ready channel. The
// last beat of each burst is flagged with w_last_o.
//
// Build option: define AXI_W_BEAT_GEN_BTB_EN to accept the next descriptor
// on the final beat of the current burst, giving back-to-back bursts with no
// idle cycle. With the macro undefined, descriptors are accepted only in
// IDLE, so consecutive bursts are separated by at least one bubble.
module axi_w_beat_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  desc_len_i,
  input  logic                  desc_valid_i,
  output logic                  desc_ready_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_o,
  output logic [DATA_WIDTH-1:0] w_data_o,
  output logic                  w_last_o,
  output logic                  w_valid_o,
  input  logic                  w_ready_i,
  output logic                  busy_o,
  output logic [LEN_WIDTH:0]    beats_left_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  // One extra counter bit so that len = 2**LEN_WIDTH-1 loads as a full
  // 2**LEN_WIDTH beats instead of wrapping to zero.
  localparam logic [LEN_WIDTH:0] CNT_ONE = {{LEN_WIDTH{1'b0}}, 1'b1};

  logic [0:0]         state;
  logic [LEN_WIDTH:0] cnt;
  logic               in_burst;
  logic               last_cnt;
  logic               beat;
  logic               desc_hs;
  logic [LEN_WIDTH:0] cnt_load;

  assign in_burst = (state == BURST);
  assign last_cnt = (cnt == CNT_ONE);
  assign cnt_load = {1'b0, desc_len_i} + CNT_ONE;

  // The FIFO head is presented as-is; it cannot change without a pop, so
  // data and last stay stable for as long as valid is held.
  assign w_valid_o    = in_burst & ~fifo_empty_i;
  assign w_data_o     = fifo_data_i;
  assign w_last_o     = w_valid_o & last_cnt;
  assign beat         = w_valid_o & w_ready_i;
  assign fifo_rd_o    = beat;
  assign busy_o       = in_burst;
  // cnt is zero whenever the block is idle, so it can be shown directly.
  assign beats_left_o = cnt;
  assign desc_hs      = desc_valid_i & desc_ready_o;

  // Descriptor acceptance: always in IDLE, optionally on the closing beat.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    desc_ready_o = 1'b0;
    if (!in_burst) begin
      desc_ready_o = 1'b1;
    end else begin
`ifdef AXI_W_BEAT_GEN_BTB_EN
      desc_ready_o = last_cnt & beat;
`else
      desc_ready_o = 1'b0;
`endif
    end
  end

  // Burst state and remaining-beat counter.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (desc_hs) begin
            cnt   <= cnt_load;
            state <= BURST;
          end
        end
        BURST: begin
          if (beat) begin
            if (!last_cnt) begin
              cnt <= cnt - CNT_ONE;
            end else if (desc_hs) begin
              // Only reachable with back-to-back enabled: chain the next burst.
              cnt <= cnt_load;
            end else begin
              cnt   <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_w_beat_gen.sv
// Self-checking bench for axi_w_beat_gen. A queue-based FIFO model feeds the
// DUT; a reference model tracks the beats owed by the accepted bursts as a
// plain integer and predicts every output each cycle.
module tb_axi_w_beat_gen;

  localparam int DW = 32;
  localparam int LW = 8;
`ifdef AXI_W_BEAT_GEN_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] desc_len_i;
  logic          desc_valid_i;
  logic          desc_ready_o;
  logic [DW-1:0] fifo_data_i;
  logic          fifo_empty_i;
  logic          fifo_rd_o;
  logic [DW-1:0] w_data_o;
  logic          w_last_o;
  logic          w_valid_o;
  logic          w_ready_i;
  logic          busy_o;
  logic [LW:0]   beats_left_o;

  axi_w_beat_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .desc_len_i   (desc_len_i),
    .desc_valid_i (desc_valid_i),
    .desc_ready_o (desc_ready_o),
    .fifo_data_i  (fifo_data_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rd_o    (fifo_rd_o),
    .w_data_o     (w_data_o),
    .w_last_o     (w_last_o),
    .w_valid_o    (w_valid_o),
    .w_ready_i    (w_ready_i),
    .busy_o       (busy_o),
    .beats_left_o (beats_left_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] fifo_q[$];   // FIFO contents, head at index 0
  int            desc_q[$];   // descriptors waiting to be offered (len)
  int            rem   = 0;   // beats still owed by the current burst
  int            cyc   = 0;
  int            n_beats = 0;
  int            n_lasts = 0;
  int            beat_cyc[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic cycle(input bit wr);
    bit empty, exp_valid, exp_beat, exp_ready, dv;
    int len;
    dv           = (desc_q.size() != 0);
    len          = dv ? desc_q[0] : 0;
    desc_valid_i = dv;
    desc_len_i   = LW'(len);
    w_ready_i    = wr;
    empty        = (fifo_q.size() == 0);
    fifo_empty_i = empty;
    fifo_data_i  = empty ? 32'hDEAD_BEEF : fifo_q[0];
    #1;
    exp_valid = (rem != 0) && !empty;
    exp_beat  = exp_valid && wr;
    exp_ready = (rem == 0) || (BTB && rem == 1 && exp_beat);
    check("w_valid", w_valid_o, exp_valid);
    check("fifo_rd", fifo_rd_o, exp_beat);
    check("busy", busy_o, rem != 0);
    check("beats_left", beats_left_o, rem);
    check("desc_ready", desc_ready_o, exp_ready);
    check("w_last", w_last_o, exp_valid && rem == 1);
    if (exp_valid) check("w_data", w_data_o, fifo_q[0]);
    if (fifo_rd_o) begin
      n_beats++;
      beat_cyc.push_back(cyc);
      if (w_last_o) n_lasts++;
    end
    @(posedge clk);
    cyc++;
    if (exp_beat) begin
      void'(fifo_q.pop_front());
      rem = rem - 1;
    end
    if (dv && exp_ready) begin
      void'(desc_q.pop_front());
      rem = len + 1;
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_desc_ready"}, desc_ready_o, 1'b1);
    check({tag, "_w_valid"}, w_valid_o, 1'b0);
    check({tag, "_w_last"}, w_last_o, 1'b0);
    check({tag, "_fifo_rd"}, fifo_rd_o, 1'b0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_beats_left"}, beats_left_o, 0);
  endtask

  initial begin
    int b0, l0, budget;
    rst = 1'b1;
    desc_valid_i = 1'b0;
    desc_len_i = '0;
    w_ready_i = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single beat: data and last on the first cycle after acceptance.
    fifo_q.push_back(32'hA5);
    desc_q.push_back(0);
    cycle(1'b1);
    check("single_busy", busy_o, 1'b1);
    b0 = n_beats;
    repeat (2) cycle(1'b1);
    check("single_beats", n_beats - b0, 1);
    check("single_idle", busy_o, 1'b0);

    // Four beats with continuous ready.
    for (int i = 0; i < 4; i++) fifo_q.push_back(32'h10 + i);
    desc_q.push_back(3);
    b0 = n_beats; l0 = n_lasts;
    repeat (6) cycle(1'b1);
    check("four_beats", n_beats - b0, 4);
    check("four_lasts", n_lasts - l0, 1);

    // Backpressure: valid and data held while ready is low.
    fifo_q.push_back(32'h55); fifo_q.push_back(32'h66);
    desc_q.push_back(1);
    cycle(1'b0);
    repeat (3) cycle(1'b0);
    check("bp_data_held", w_data_o, 32'h55);
    repeat (3) cycle(1'b1);
    check("bp_done", busy_o, 1'b0);

    // Underrun: two entries for a four-beat burst, then the rest arrives.
    fifo_q.push_back(32'h70); fifo_q.push_back(32'h71);
    desc_q.push_back(3);
    repeat (5) cycle(1'b1);
    check("underrun_left", beats_left_o, 2);
    check("underrun_valid", w_valid_o, 1'b0);
    fifo_q.push_back(32'h72); fifo_q.push_back(32'h73);
    l0 = n_lasts;
    repeat (3) cycle(1'b1);
    check("underrun_last", n_lasts - l0, 1);
    check("underrun_done", busy_o, 1'b0);

    // Maximum length: 256 beats, one last, no counter wrap.
    for (int i = 0; i < 256; i++) fifo_q.push_back($urandom);
    desc_q.push_back(255);
    b0 = n_beats; l0 = n_lasts;
    repeat (259) cycle(1'b1);
    check("max_beats", n_beats - b0, 256);
    check("max_lasts", n_lasts - l0, 1);

    // Reset in the middle of a burst.
    for (int i = 0; i < 8; i++) fifo_q.push_back(32'h80 + i);
    desc_q.push_back(7);
    repeat (3) cycle(1'b1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    rem = 0;
    fifo_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    cyc++;
    #1;

    // Back-to-back: len=1 then len=2 offered immediately.
    for (int i = 0; i < 5; i++) fifo_q.push_back(32'h90 + i);
    desc_q.push_back(1); desc_q.push_back(2);
    beat_cyc.delete();
    budget = 0;
    while ((beat_cyc.size() < 5) && (budget < 20)) begin
      cycle(1'b1);
      budget++;
    end
    check("btb_beats", beat_cyc.size(), 5);
    if (beat_cyc.size() == 5)
      check("btb_span", beat_cyc[4] - beat_cyc[0] + 1, BTB ? 5 : 6);
    repeat (2) cycle(1'b1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if (desc_q.size() == 0 && ($urandom_range(0, 3) == 0))
        desc_q.push_back(($urandom_range(0, 15) == 0) ? $urandom_range(0, 255)
                                                      : $urandom_range(0, 7));
      if (fifo_q.size() < 300 && ($urandom_range(0, 9) < 6))
        fifo_q.push_back($urandom);
      cycle($urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
